// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the dual seven-segment display
// multiplexer.
//   disp_state_t : controller frame states.
//   SEG_BLANK    : all segments off (segment outputs are active-low).
//   SEG_LUT      : hex nibble -> {g,f,e,d,c,b,a} segment pattern, active-low.
package display_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ON0    = 3'd1,
    BLANK0 = 3'd2,
    ON1    = 3'd3,
    BLANK1 = 3'd4
  } disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: purely combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit value to display
//   seg    : {g,f,e,d,c,b,a}, active-low (0 = segment lit)
module sevenseg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg = SEG_LUT[nibble];
  end

endmodule

// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl: time-multiplexes one shared seven-segment decoder between
// digit 0 (switch1) and digit 1 (switch2), with dead-time blanking between the
// digits. Both nibbles are captured once at frame start so a digit never
// changes mid-frame.
//   clk        : system clock
//   reset      : synchronous, active-low reset
//   switch1    : nibble for digit 0
//   switch2    : nibble for digit 1
//   enable     : display enable, only looked at when a frame could start
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   an0 / an1  : digit anode drives, active-low
//   frame_tick : one-cycle pulse in the first lit cycle of every frame
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int ON_CYCLES    = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] switch1,
  input  logic [3:0] switch2,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       an0,
  output logic       an1,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  disp_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lat0_q, lat0_d;
  logic [3:0]       lat1_q, lat1_d;

  logic [3:0]       dec_nibble_s;
  logic [6:0]       dec_seg_s;
  logic             cnt_done_s;

  assign cnt_done_s = (cnt_q == CNT_ZERO);

  // Next-state, counter reload/decrement and frame-start nibble capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat0_d  = lat0_q;
    lat1_d  = lat1_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ON0;
          cnt_d   = ON_LOAD;
          lat0_d  = switch1;
          lat1_d  = switch2;
        end else begin
          state_d = IDLE;
        end
      end
      ON0: begin
        if (cnt_done_s) begin
          state_d = BLANK0;
          cnt_d   = BLANK_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BLANK0: begin
        if (cnt_done_s) begin
          state_d = ON1;
          cnt_d   = ON_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ON1: begin
        if (cnt_done_s) begin
          state_d = BLANK1;
          cnt_d   = BLANK_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BLANK1: begin
        // Frame end: enable decides between a fresh frame and going idle.
        if (cnt_done_s) begin
          if (enable) begin
            state_d = ON0;
            cnt_d   = ON_LOAD;
            lat0_d  = switch1;
            lat1_d  = switch2;
          end else begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and capture registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      lat0_q  <= 4'h0;
      lat1_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat0_q  <= lat0_d;
      lat1_q  <= lat1_d;
    end
  end

  // Steer the shared decoder to whichever digit is lit.
  always_comb begin
    if (state_q == ON1) begin
      dec_nibble_s = lat1_q;
    end else begin
      dec_nibble_s = lat0_q;
    end
  end

  sevenseg_decoder u_decoder (
    .nibble (dec_nibble_s),
    .seg    (dec_seg_s)
  );

  // Anode and blank gating; only the ON states ever light anything.
  always_comb begin
    seg        = SEG_BLANK;
    an0        = 1'b1;
    an1        = 1'b1;
    frame_tick = 1'b0;
    case (state_q)
      ON0: begin
        seg        = dec_seg_s;
        an0        = 1'b0;
        // The counter is still at its reload value only in the first ON0 cycle.
        frame_tick = (cnt_q == ON_LOAD);
      end
      ON1: begin
        seg = dec_seg_s;
        an1 = 1'b0;
      end
      default: begin
        seg        = SEG_BLANK;
        an0        = 1'b1;
        an1        = 1'b1;
        frame_tick = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// tb_display_mux_ctrl: directed and randomized stimulus for display_mux_ctrl,
// checked every cycle against a frame-position reference model.
module tb_display_mux_ctrl;

  localparam int ON    = 4;
  localparam int BLANK = 2;
  localparam int FRAME = 2 * (ON + BLANK);

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] switch1;
  logic [3:0] switch2;
  logic       enable;
  logic [6:0] seg;
  logic       an0;
  logic       an1;
  logic       frame_tick;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: idle flag, position within frame, captured nibbles.
  bit       m_idle = 1'b1;
  int       m_t    = 0;
  bit [3:0] m_l0   = 4'h0;
  bit [3:0] m_l1   = 4'h0;

  logic [6:0] exp_lut [0:15];

  display_mux_ctrl #(
    .ON_CYCLES    (ON),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .switch1    (switch1),
    .switch2    (switch2),
    .enable     (enable),
    .seg        (seg),
    .an0        (an0),
    .an1        (an1),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model one clock edge using the inputs visible at that edge.
  task automatic model_edge();
    if (!reset) begin
      m_idle = 1'b1;
      m_t    = 0;
      m_l0   = 4'h0;
      m_l1   = 4'h0;
    end else if (m_idle || m_t == FRAME - 1) begin
      if (enable) begin
        m_idle = 1'b0;
        m_t    = 0;
        m_l0   = switch1;
        m_l1   = switch2;
      end else begin
        m_idle = 1'b1;
      end
    end else begin
      m_t = m_t + 1;
    end
  endtask

  // One clock: update model at posedge, compare outputs at the following negedge.
  task automatic step();
    logic [6:0] e_seg;
    logic       e_an0, e_an1, e_tick;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e_seg = 7'h7F; e_an0 = 1'b1; e_an1 = 1'b1; e_tick = 1'b0;
    if (!m_idle) begin
      if (m_t < ON) begin
        e_seg = exp_lut[m_l0]; e_an0 = 1'b0; e_tick = (m_t == 0);
      end else if (m_t >= ON + BLANK && m_t < 2 * ON + BLANK) begin
        e_seg = exp_lut[m_l1]; e_an1 = 1'b0;
      end
    end
    check("seg", seg, e_seg);
    check("an0", an0, e_an0);
    check("an1", an1, e_an1);
    check("frame_tick", frame_tick, e_tick);
    check("an_exclusive", an0 | an1, 1'b1);
    if (!an0 || !an1) check("lit_not_blank", seg != 7'h7F, 1'b1);
  endtask

  // Step until the model sits at frame position pos (bounded).
  task automatic wait_pos(input int pos);
    int k;
    for (k = 0; k < 100; k++) begin
      if (!m_idle && m_t == pos) break;
      step();
    end
    if (k == 100) check("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    exp_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset = 1'b0; enable = 1'b1; switch1 = 4'h3; switch2 = 4'hA;

    // 1: reset held with enable high keeps everything dark.
    repeat (3) step();
    check("rst_seg", seg, 7'h7F);
    check("rst_an", {an0, an1}, 2'b11);

    // 2: first frame after release.
    reset = 1'b1;
    step();
    check("t2_tick", frame_tick, 1'b1);
    check("t2_seg0", seg, 7'h30);
    repeat (ON + BLANK) step();
    check("t2_seg1", seg, 7'h08);
    check("t2_an1", an1, 1'b0);
    repeat (ON + BLANK) step();
    check("t2_tick_again", frame_tick, 1'b1);

    // 3: switch change mid-ON0 ignored until next capture.
    step();
    switch1 = 4'h8;
    wait_pos(0);
    check("t3_new_capture", seg, 7'h00);

    // 4: enable dropped during ON1; frame finishes then idles.
    wait_pos(ON + BLANK);
    enable = 1'b0;
    repeat (ON + BLANK + 4) step();
    check("t4_idle_seg", seg, 7'h7F);
    check("t4_idle_an", {an0, an1}, 2'b11);
    enable = 1'b1;
    step();
    check("t4_restart_tick", frame_tick, 1'b1);

    // 5: reset in cycle 2 of ON1, then fresh capture of switch1.
    wait_pos(ON + BLANK + 1);
    reset = 1'b0;
    step();
    check("t5_reset_seg", seg, 7'h7F);
    reset = 1'b1; switch1 = 4'h5;
    step();
    check("t5_digit0", an0, 1'b0);
    check("t5_seg", seg, 7'h12);

    // 6: sweep all nibbles on switch1, one per frame.
    for (int n = 0; n < 16; n++) begin
      wait_pos(FRAME - 1);
      switch1 = n[3:0];
      switch2 = 4'(15 - n);
      step();
      check("t6_sweep", seg, exp_lut[n]);
    end

    // Randomized run: switches every cycle, enable mostly high, rare resets.
    for (int c = 0; c < 600; c++) begin
      switch1 = 4'($urandom_range(0, 15));
      switch2 = 4'($urandom_range(0, 15));
      enable  = ($urandom_range(0, 9) < 8);
      reset   = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
